// File: rtl/rv_dispatch_pkg.sv
// rv_dispatch_pkg: shared types and constants for the dispatch stage.
// Instruction class enum, payload width, opcode constants, class decode helper.
package rv_dispatch_pkg;

    typedef enum logic [1:0] {
        CLS_INT = 2'd0,
        CLS_MEM = 2'd1,
        CLS_BR  = 2'd2
    } cls_e;

    localparam int PAYLOAD_W = 96;

    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;

    // Memory wins over control flow; anything else is plain ALU work.
    function automatic cls_e classify(
        input logic memread,
        input logic memwrite,
        input logic br,
        input logic j
    );
        if (memread || memwrite) begin
            return CLS_MEM;
        end else if (br || j) begin
            return CLS_BR;
        end else begin
            return CLS_INT;
        end
    endfunction

endpackage

// File: rtl/credit_counter.sv
// credit_counter: free-entry tracker for one issue queue.
// Ports: dec (accept), inc (credit return), flush_reload; count, nonzero, sticky err.
module credit_counter
    import rv_dispatch_pkg::*;
#(
    parameter int DEPTH = 4,
    localparam int CW = $clog2(DEPTH + 1)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          dec,
    input  logic          inc,
    input  logic          flush_reload,
    output logic [CW-1:0] count,
    output logic          nonzero,
    output logic          err
);

    localparam logic [CW-1:0] FULL = CW'(DEPTH);

    logic [CW-1:0] count_q, count_d;
    logic          err_q, err_d;

    always_comb begin
        count_d = count_q;
        err_d   = err_q;
        if (flush_reload) begin
            count_d = FULL;
        end else if (dec && !inc) begin
            count_d = count_q - 1'b1;
        end else if (inc && !dec) begin
            // A return while already full means the queue lied about an entry.
            if (count_q == FULL) begin
                err_d = 1'b1;
            end else begin
                count_d = count_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= FULL;
            err_q   <= 1'b0;
        end else begin
            count_q <= count_d;
            err_q   <= err_d;
        end
    end

    assign count   = count_q;
    assign nonzero = (count_q != '0);
    assign err     = err_q;

endmodule

// File: rtl/dispatch_controller.sv
// dispatch_controller: classifies decoded instrs, credit/tag guards, 1-cycle dispatch pulse.
// Ports: du_* handshake in, *_credit/commit/flush in, disp_* pulse out, sticky credit_err.
// Optional DISPATCH_PERF_CNT_EN adds stall_credit_cnt / stall_tag_cnt.
module dispatch_controller
    import rv_dispatch_pkg::*;
#(
    parameter int INT_DEPTH = 4,
    parameter int MEM_DEPTH = 4,
    parameter int BR_DEPTH  = 2,
    parameter int TAG_W     = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 du_valid,
    output logic                 du_ready,
    input  logic                 du_memread,
    input  logic                 du_memwrite,
    input  logic                 du_br,
    input  logic                 du_j,
    input  logic [PAYLOAD_W-1:0] du_payload,
    input  logic                 int_credit,
    input  logic                 mem_credit,
    input  logic                 br_credit,
    input  logic                 commit,
    input  logic                 flush,
    output logic                 disp_int_valid,
    output logic                 disp_mem_valid,
    output logic                 disp_br_valid,
    output logic [PAYLOAD_W-1:0] disp_payload,
    output logic [TAG_W-1:0]     disp_tag,
    output logic                 credit_err
`ifdef DISPATCH_PERF_CNT_EN
    ,
    output logic [31:0]          stall_credit_cnt,
    output logic [31:0]          stall_tag_cnt
`endif
);

    localparam logic [TAG_W:0] TAG_N = (TAG_W + 1)'(2 ** TAG_W);

    cls_e cls;
    logic credit_ok, tag_full, accept;
    logic int_nz, mem_nz, br_nz;
    logic int_err, mem_err, br_err;

    logic [$clog2(INT_DEPTH+1)-1:0] unused_int_cnt;
    logic [$clog2(MEM_DEPTH+1)-1:0] unused_mem_cnt;
    logic [$clog2(BR_DEPTH+1)-1:0]  unused_br_cnt;

    logic [TAG_W:0]         inflight_q, inflight_d;
    logic [TAG_W-1:0]       alloc_ptr_q, alloc_ptr_d;
    logic                   int_v_q, int_v_d;
    logic                   mem_v_q, mem_v_d;
    logic                   br_v_q, br_v_d;
    logic [PAYLOAD_W-1:0]   payload_q, payload_d;
    logic [TAG_W-1:0]       tag_q, tag_d;

    assign cls = classify(du_memread, du_memwrite, du_br, du_j);

    always_comb begin
        credit_ok = 1'b0;
        unique case (cls)
            CLS_INT: credit_ok = int_nz;
            CLS_MEM: credit_ok = mem_nz;
            CLS_BR:  credit_ok = br_nz;
            default: credit_ok = 1'b0;
        endcase
    end

    assign tag_full = (inflight_q == TAG_N);
    assign du_ready = !flush && credit_ok && !tag_full;
    assign accept   = du_valid && du_ready;

    credit_counter #(.DEPTH(INT_DEPTH)) u_int_cc (
        .clk(clk), .rst_n(rst_n),
        .dec(accept && cls == CLS_INT),
        .inc(int_credit), .flush_reload(flush),
        .count(unused_int_cnt), .nonzero(int_nz), .err(int_err)
    );

    credit_counter #(.DEPTH(MEM_DEPTH)) u_mem_cc (
        .clk(clk), .rst_n(rst_n),
        .dec(accept && cls == CLS_MEM),
        .inc(mem_credit), .flush_reload(flush),
        .count(unused_mem_cnt), .nonzero(mem_nz), .err(mem_err)
    );

    credit_counter #(.DEPTH(BR_DEPTH)) u_br_cc (
        .clk(clk), .rst_n(rst_n),
        .dec(accept && cls == CLS_BR),
        .inc(br_credit), .flush_reload(flush),
        .count(unused_br_cnt), .nonzero(br_nz), .err(br_err)
    );

    always_comb begin
        inflight_d  = inflight_q;
        alloc_ptr_d = alloc_ptr_q + {{(TAG_W-1){1'b0}}, accept};
        if (flush) begin
            inflight_d = '0;
        end else if (accept && !(commit && inflight_q != '0)) begin
            inflight_d = inflight_q + 1'b1;
        end else if (!accept && commit && inflight_q != '0) begin
            inflight_d = inflight_q - 1'b1;
        end
        int_v_d   = accept && cls == CLS_INT;
        mem_v_d   = accept && cls == CLS_MEM;
        br_v_d    = accept && cls == CLS_BR;
        payload_d = accept ? du_payload : payload_q;
        tag_d     = accept ? alloc_ptr_q : tag_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            inflight_q  <= '0;
            alloc_ptr_q <= '0;
            int_v_q     <= 1'b0;
            mem_v_q     <= 1'b0;
            br_v_q      <= 1'b0;
            payload_q   <= '0;
            tag_q       <= '0;
        end else begin
            inflight_q  <= inflight_d;
            alloc_ptr_q <= alloc_ptr_d;
            int_v_q     <= int_v_d;
            mem_v_q     <= mem_v_d;
            br_v_q      <= br_v_d;
            payload_q   <= payload_d;
            tag_q       <= tag_d;
        end
    end

    assign disp_int_valid = int_v_q;
    assign disp_mem_valid = mem_v_q;
    assign disp_br_valid  = br_v_q;
    assign disp_payload   = payload_q;
    assign disp_tag       = tag_q;
    assign credit_err     = int_err | mem_err | br_err;

`ifdef DISPATCH_PERF_CNT_EN
    logic [31:0] stall_credit_cnt_q, stall_credit_cnt_d;
    logic [31:0] stall_tag_cnt_q, stall_tag_cnt_d;

    // Credit starvation takes precedence when both causes coincide.
    always_comb begin
        stall_credit_cnt_d = stall_credit_cnt_q;
        stall_tag_cnt_d    = stall_tag_cnt_q;
        if (du_valid && !flush && !credit_ok) begin
            if (stall_credit_cnt_q != '1) begin
                stall_credit_cnt_d = stall_credit_cnt_q + 1'b1;
            end
        end else if (du_valid && !flush && tag_full) begin
            if (stall_tag_cnt_q != '1) begin
                stall_tag_cnt_d = stall_tag_cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_credit_cnt_q <= '0;
            stall_tag_cnt_q    <= '0;
        end else begin
            stall_credit_cnt_q <= stall_credit_cnt_d;
            stall_tag_cnt_q    <= stall_tag_cnt_d;
        end
    end

    assign stall_credit_cnt = stall_credit_cnt_q;
    assign stall_tag_cnt    = stall_tag_cnt_q;
`endif

endmodule

// File: tb/tb_dispatch_controller.sv
// tb_dispatch_controller: directed + random stimulus against a queue-level model.
// Model tracks free credits, in-flight count and next tag with plain integers.
module tb_dispatch_controller;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        du_valid, du_ready;
    logic        du_memread, du_memwrite, du_br, du_j;
    logic [95:0] du_payload;
    logic        int_credit, mem_credit, br_credit, commit, flush;
    logic        disp_int_valid, disp_mem_valid, disp_br_valid;
    logic [95:0] disp_payload;
    logic [3:0]  disp_tag;
    logic        credit_err;

    int total = 0;
    int bad   = 0;

    int    dep[3] = '{4, 4, 2};
    int    cred[3];
    int    inflight, alloc;
    bit    m_err;
    bit    exp_v[3];
    logic [95:0] exp_pl;
    int    exp_tag;

    always #5 clk = ~clk;

    dispatch_controller dut (
        .clk(clk), .rst_n(rst_n),
        .du_valid(du_valid), .du_ready(du_ready),
        .du_memread(du_memread), .du_memwrite(du_memwrite),
        .du_br(du_br), .du_j(du_j), .du_payload(du_payload),
        .int_credit(int_credit), .mem_credit(mem_credit),
        .br_credit(br_credit), .commit(commit), .flush(flush),
        .disp_int_valid(disp_int_valid), .disp_mem_valid(disp_mem_valid),
        .disp_br_valid(disp_br_valid), .disp_payload(disp_payload),
        .disp_tag(disp_tag), .credit_err(credit_err)
    );

    task automatic chk(input string tag, input logic [127:0] obs,
                       input logic [127:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s got=%0h want=%0h", tag, obs, exp);
        end
    endtask

    function automatic int cls_of(input bit mr, mw, b, jj);
        if (mr || mw) return 1;
        if (b || jj)  return 2;
        return 0;
    endfunction

    task automatic m_reset();
        for (int k = 0; k < 3; k++) begin
            cred[k]  = dep[k];
            exp_v[k] = 1'b0;
        end
        inflight = 0;
        alloc    = 0;
        m_err    = 1'b0;
        exp_pl   = '0;
        exp_tag  = 0;
    endtask

    task automatic set_in(input bit v, input int c, input bit ic, mc, bc,
                          cm, fl);
        du_valid    = v;
        du_memread  = (c == 1);
        du_memwrite = 1'b0;
        du_br       = (c == 2);
        du_j        = 1'b0;
        du_payload  = {$urandom, $urandom, $urandom};
        int_credit  = ic;
        mem_credit  = mc;
        br_credit   = bc;
        commit      = cm;
        flush       = fl;
    endtask

    task automatic cycle();
        int c;
        bit rdy, acc, d, i;
        bit crd[3];
        @(negedge clk);
        c   = cls_of(du_memread, du_memwrite, du_br, du_j);
        rdy = !flush && cred[c] > 0 && inflight < 16;
        chk("du_ready", du_ready, rdy);
        acc = du_valid && rdy;
        crd = '{int_credit, mem_credit, br_credit};
        if (flush) begin
            for (int k = 0; k < 3; k++) cred[k] = dep[k];
            inflight = 0;
        end else begin
            for (int k = 0; k < 3; k++) begin
                d = acc && c == k;
                i = crd[k];
                if (d && !i) cred[k]--;
                else if (i && !d) begin
                    if (cred[k] == dep[k]) m_err = 1'b1;
                    else cred[k]++;
                end
            end
            inflight = inflight + (acc ? 1 : 0)
                     - ((commit && inflight > 0) ? 1 : 0);
        end
        for (int k = 0; k < 3; k++) exp_v[k] = acc && c == k;
        if (acc) begin
            exp_pl  = du_payload;
            exp_tag = alloc;
            alloc   = (alloc + 1) % 16;
        end
        @(posedge clk);
        #1;
        chk("v_int", disp_int_valid, exp_v[0]);
        chk("v_mem", disp_mem_valid, exp_v[1]);
        chk("v_br", disp_br_valid, exp_v[2]);
        chk("payload", disp_payload, exp_pl);
        chk("tag", disp_tag, exp_tag);
        chk("credit_err", credit_err, m_err);
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_int"}, disp_int_valid, 1'b0);
        chk({tag, "_mem"}, disp_mem_valid, 1'b0);
        chk({tag, "_br"}, disp_br_valid, 1'b0);
        chk({tag, "_pl"}, disp_payload, 96'd0);
        chk({tag, "_tag"}, disp_tag, 4'd0);
        chk({tag, "_err"}, credit_err, 1'b0);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        set_in(0, 0, 0, 0, 0, 0, 0);
        m_reset();
        #12;
        chk_zero("rst");
        chk("rst_ready", du_ready, 1'b1);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [3:0] bits;
        do_reset();

        // five INT, four credits: tags 0..3, then stall until a credit
        for (int n = 0; n < 4; n++) begin
            set_in(1, 0, 0, 0, 0, 0, 0);
            cycle();
            chk("t1_tag", disp_tag, n);
        end
        set_in(1, 0, 0, 0, 0, 0, 0);
        cycle();
        chk("t1_stall", disp_int_valid, 1'b0);
        set_in(1, 0, 1, 0, 0, 0, 0);
        cycle();
        set_in(1, 0, 0, 0, 0, 0, 0);
        cycle();
        chk("t1_tag4", disp_tag, 4'd4);

        // load with same-cycle mem credit: count stays full, no error
        set_in(1, 1, 0, 1, 0, 0, 0);
        cycle();
        chk("t2_vmem", disp_mem_valid, 1'b1);
        chk("t2_err", credit_err, 1'b0);
        set_in(0, 0, 0, 0, 0, 0, 0);
        cycle();
        chk("t2_vmem_off", disp_mem_valid, 1'b0);

        // sixteen in flight, then one commit lets tag 0 (wrapped) through
        do_reset();
        for (int n = 0; n < 16; n++) begin
            set_in(1, 0, 1, 0, 0, 0, 0);
            cycle();
        end
        set_in(1, 0, 0, 0, 0, 1, 0);
        cycle();
        chk("t3_full", disp_int_valid, 1'b0);
        set_in(1, 0, 0, 0, 0, 0, 0);
        cycle();
        chk("t3_wrap_v", disp_int_valid, 1'b1);
        chk("t3_wrap_tag", disp_tag, 4'd0);

        // flush with partially used credits; alloc_ptr continues
        set_in(0, 0, 0, 0, 0, 1, 0);
        cycle();
        cycle();
        set_in(1, 1, 0, 0, 0, 0, 0);
        cycle();
        set_in(1, 0, 0, 0, 0, 0, 0);
        cycle();
        set_in(1, 0, 1, 0, 0, 1, 1);
        cycle();
        chk("t4_noacc", disp_int_valid, 1'b0);
        set_in(1, 0, 0, 0, 0, 0, 0);
        cycle();
        chk("t4_tag", disp_tag, 4'd3);
        for (int n = 0; n < 4; n++) cycle();

        // br credit while full: error is sticky through flush
        set_in(0, 0, 0, 0, 1, 0, 0);
        cycle();
        chk("t5_err", credit_err, 1'b1);
        set_in(0, 0, 0, 0, 0, 0, 1);
        cycle();
        chk("t5_err_flush", credit_err, 1'b1);

        // async reset in the middle of a br pulse
        set_in(1, 2, 0, 0, 0, 0, 0);
        cycle();
        chk("t6_brv", disp_br_valid, 1'b1);
        set_in(0, 0, 0, 0, 0, 0, 0);
        #2;
        rst_n = 1'b0;
        #1;
        chk_zero("arst");
        m_reset();
        rst_n = 1'b1;
        set_in(1, 0, 0, 0, 0, 0, 0);
        cycle();
        chk("t6_tag0_v", disp_int_valid, 1'b1);
        chk("t6_tag0", disp_tag, 4'd0);

        // random traffic; queues only return credits they actually hold
        for (int n = 0; n < 600; n++) begin
            bits = 4'($urandom);
            if ($urandom % 2 == 0) bits = 4'd0;
            du_valid    = ($urandom % 4) != 0;
            du_memread  = bits[0];
            du_memwrite = bits[1];
            du_br       = bits[2];
            du_j        = bits[3];
            du_payload  = {$urandom, $urandom, $urandom};
            int_credit  = cred[0] < dep[0] && ($urandom % 3) == 0;
            mem_credit  = cred[1] < dep[1] && ($urandom % 3) == 0;
            br_credit   = cred[2] < dep[2] && ($urandom % 3) == 0;
            commit      = ($urandom % 3) == 0;
            flush       = ($urandom % 25) == 0;
            cycle();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
